// File: rtl/dmem_map_pkg.sv
// Shared data_mem map, widths and sequencer state encoding.
// Used by mem_access_sequencer; no macros are consumed here.
package dmem_map_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = 4;

    localparam logic [ADDR_W-1:0] LED_ADDR      = 8'h44;
    localparam logic [ADDR_W-1:0] SW_ADDR       = 8'h4E;
    localparam logic [ADDR_W-1:0] RO_BASE_ADDR  = 8'h4E;
    localparam logic [ADDR_W-1:0] RO_LIMIT_ADDR = 8'h4F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // Inclusive address window test.
    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] lo,
                                       input logic [ADDR_W-1:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/mem_access_sequencer.sv
// Single-outstanding data_mem initiator: sequences write/read strobes and returns a one-cycle response.
// Optional feature macro: MAU_RO_GUARD_EN (blocks stores to the read-only window with a fault response).
module mem_access_sequencer
    import dmem_map_pkg::*;
#(
    parameter int unsigned       RD_LATENCY = 1,
    parameter logic [ADDR_W-1:0] RO_BASE    = RO_BASE_ADDR,
    parameter logic [ADDR_W-1:0] RO_LIMIT   = RO_LIMIT_ADDR
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic              busy,
    output logic [ADDR_W-1:0] address,
    output logic              read_en,
    output logic              write_en,
    output logic [DATA_W-1:0] input_data,
    input  logic [DATA_W-1:0] output_data
);

    if (RD_LATENCY > 15) begin : g_bad_latency
        $error("mem_access_sequencer: RD_LATENCY must be 0..15");
    end
    if (RO_BASE > RO_LIMIT) begin : g_bad_ro_window
        $error("mem_access_sequencer: RO_BASE must not exceed RO_LIMIT");
    end

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    req_t             req;
    logic             accept;
    logic             capture;
    logic             ro_store;

    assign req = '{write: req_write, addr: req_addr, wdata: req_wdata};

    // State and latency counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state and counter decode.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        capture    = 1'b0;
`ifdef MAU_RO_GUARD_EN
        ro_store   = req.write && in_window(req.addr, RO_BASE, RO_LIMIT);
`else
        ro_store   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (req.write) begin
                        state_next = ro_store ? ST_RESP : ST_WRITE;
                    end else begin
                        state_next = ST_READ;
                        cnt_next   = CNT_W'(RD_LATENCY);
                    end
                end
            end
            ST_WRITE: state_next = ST_RESP;
            ST_READ: begin
                // Counter saturates at zero; the zero cycle is the capture cycle.
                if (cnt == '0) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Registered bus strobes, handshake and response; strobes are decoded from the next state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            address    <= '0;
            input_data <= '0;
            read_en    <= 1'b0;
            write_en   <= 1'b0;
        end else begin
            req_ready  <= (state_next == ST_IDLE);
            busy       <= (state_next != ST_IDLE);
            resp_valid <= (state_next == ST_RESP);
            read_en    <= (state_next == ST_READ);
            write_en   <= (state_next == ST_WRITE);
            if (accept) begin
                address    <= req.addr;
                input_data <= req.wdata;
            end
            if (capture) begin
                resp_rdata <= output_data;
            end
        end
    end

`ifdef MAU_RO_GUARD_EN
    // A blocked store is the only path into RESP carrying a fault.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            resp_fault <= 1'b0;
        end else begin
            resp_fault <= accept && ro_store;
        end
    end
`else
    assign resp_fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: two instances (RD_LATENCY 1 and 3) with behavioural data_mem models.
// Guard-dependent expectations follow MAU_RO_GUARD_EN.
module tb_mem_access_sequencer;

    logic        clk;
    logic        rst1, rst3;
    logic        req_valid, req_write;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [15:0] sw;

    logic        r1_ready, r1_resp_valid, r1_fault, r1_busy, r1_rd, r1_wr;
    logic [15:0] r1_rdata, r1_wdata, r1_odata;
    logic [7:0]  r1_addr;
    logic        r3_ready, r3_resp_valid, r3_fault, r3_busy, r3_rd, r3_wr;
    logic [15:0] r3_rdata, r3_wdata, r3_odata;
    logic [7:0]  r3_addr;

    logic [15:0] mem1 [0:255];
    logic [15:0] mem3 [0:255];
    logic [15:0] led1, pipe1, p3a, p3b, p3c;

    int n_cmp;
    int n_bad;

    mem_access_sequencer #(.RD_LATENCY(1)) u_dut1 (
        .CLK(clk), .RST(rst1),
        .req_valid(req_valid), .req_ready(r1_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(r1_resp_valid), .resp_rdata(r1_rdata), .resp_fault(r1_fault),
        .busy(r1_busy), .address(r1_addr), .read_en(r1_rd), .write_en(r1_wr),
        .input_data(r1_wdata), .output_data(r1_odata)
    );

    mem_access_sequencer #(.RD_LATENCY(3)) u_dut3 (
        .CLK(clk), .RST(rst3),
        .req_valid(req_valid), .req_ready(r3_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(r3_resp_valid), .resp_rdata(r3_rdata), .resp_fault(r3_fault),
        .busy(r3_busy), .address(r3_addr), .read_en(r3_rd), .write_en(r3_wr),
        .input_data(r3_wdata), .output_data(r3_odata)
    );

    always #5 clk = ~clk;

    // data_mem models: RAM with read-only switch window, LED register, fixed read pipeline.
    always @(posedge clk) begin
        if (r1_wr) begin
            if (r1_addr != 8'h4E && r1_addr != 8'h4F) mem1[r1_addr] <= r1_wdata;
            if (r1_addr == 8'h44) led1 <= r1_wdata;
        end
        if (r1_rd) pipe1 <= (r1_addr == 8'h4E) ? sw : mem1[r1_addr];
    end
    assign r1_odata = pipe1;

    always @(posedge clk) begin
        if (r3_wr && r3_addr != 8'h4E && r3_addr != 8'h4F) mem3[r3_addr] <= r3_wdata;
        if (r3_rd) p3a <= (r3_addr == 8'h4E) ? sw : mem3[r3_addr];
        p3b <= p3a;
        p3c <= p3b;
    end
    assign r3_odata = p3c;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({r1_ready, r1_busy, r1_resp_valid, r1_fault, r1_rd, r1_wr} !== 6'b100000) begin
            n_bad++;
            $display("FAIL reset_ctrl1: got %b exp 100000",
                     {r1_ready, r1_busy, r1_resp_valid, r1_fault, r1_rd, r1_wr});
        end
        n_cmp++;
        if ({r1_addr, r1_wdata, r1_rdata} !== 40'h0) begin
            n_bad++;
            $display("FAIL reset_data1: got %h exp 0", {r1_addr, r1_wdata, r1_rdata});
        end
        n_cmp++;
        if ({r3_ready, r3_busy, r3_resp_valid, r3_fault, r3_rd, r3_wr} !== 6'b100000) begin
            n_bad++;
            $display("FAIL reset_ctrl3: got %b exp 100000",
                     {r3_ready, r3_busy, r3_resp_valid, r3_fault, r3_rd, r3_wr});
        end
    endtask

    task automatic test_store_load;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h74; req_wdata = 16'hABCD;
        tick;
        req_valid = 1'b0;
        n_cmp++;
        if ({r1_wr, r1_rd, r1_ready, r1_busy} !== 4'b1001 || r1_addr !== 8'h74 || r1_wdata !== 16'hABCD) begin
            n_bad++;
            $display("FAIL store_t1: wr/rd/rdy/busy=%b addr=%h data=%h exp 1001 74 abcd",
                     {r1_wr, r1_rd, r1_ready, r1_busy}, r1_addr, r1_wdata);
        end
        tick;
        n_cmp++;
        if ({r1_wr, r1_resp_valid, r1_fault, r1_ready} !== 4'b0100) begin
            n_bad++;
            $display("FAIL store_t2: wr/rv/flt/rdy=%b exp 0100", {r1_wr, r1_resp_valid, r1_fault, r1_ready});
        end
        tick;
        n_cmp++;
        if ({r1_ready, r1_busy, r1_resp_valid, r1_wr} !== 4'b1000) begin
            n_bad++;
            $display("FAIL store_t3: rdy/busy/rv/wr=%b exp 1000", {r1_ready, r1_busy, r1_resp_valid, r1_wr});
        end
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h74;
        tick;
        req_valid = 1'b0;
        n_cmp++;
        if ({r1_rd, r1_wr, r1_resp_valid} !== 3'b100) begin
            n_bad++;
            $display("FAIL load_t1: rd/wr/rv=%b exp 100", {r1_rd, r1_wr, r1_resp_valid});
        end
        tick;
        n_cmp++;
        if ({r1_rd, r1_wr, r1_resp_valid} !== 3'b100) begin
            n_bad++;
            $display("FAIL load_t2: rd/wr/rv=%b exp 100", {r1_rd, r1_wr, r1_resp_valid});
        end
        tick;
        n_cmp++;
        if ({r1_rd, r1_resp_valid, r1_fault} !== 3'b010 || r1_rdata !== 16'hABCD) begin
            n_bad++;
            $display("FAIL load_t3: rd/rv/flt=%b rdata=%h exp 010 abcd", {r1_rd, r1_resp_valid, r1_fault}, r1_rdata);
        end
        tick;
        n_cmp++;
        if ({r1_ready, r1_resp_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL load_t4: rdy/rv=%b exp 10", {r1_ready, r1_resp_valid});
        end
    endtask

    task automatic test_led;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h44; req_wdata = 16'h1234;
        tick;
        req_valid = 1'b0;
        n_cmp++;
        if (r1_wr !== 1'b1) begin
            n_bad++;
            $display("FAIL led_wr: got %b exp 1", r1_wr);
        end
        tick;
        n_cmp++;
        if (led1 !== 16'h1234 || {r1_resp_valid, r1_fault} !== 2'b10) begin
            n_bad++;
            $display("FAIL led_out: led=%h rv/flt=%b exp 1234 10", led1, {r1_resp_valid, r1_fault});
        end
        tick;
    endtask

    task automatic test_ro_store;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h4E; req_wdata = 16'h9876;
        tick;
        req_valid = 1'b0;
`ifdef MAU_RO_GUARD_EN
        n_cmp++;
        if ({r1_wr, r1_resp_valid, r1_fault} !== 3'b011) begin
            n_bad++;
            $display("FAIL ro_guard_t1: wr/rv/flt=%b exp 011", {r1_wr, r1_resp_valid, r1_fault});
        end
        tick;
        n_cmp++;
        if ({r1_ready, r1_resp_valid, r1_fault, r1_wr} !== 4'b1000) begin
            n_bad++;
            $display("FAIL ro_guard_t2: rdy/rv/flt/wr=%b exp 1000", {r1_ready, r1_resp_valid, r1_fault, r1_wr});
        end
`else
        n_cmp++;
        if ({r1_wr, r1_resp_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL ro_store_t1: wr/rv=%b exp 10", {r1_wr, r1_resp_valid});
        end
        tick;
        n_cmp++;
        if ({r1_wr, r1_resp_valid, r1_fault} !== 3'b010) begin
            n_bad++;
            $display("FAIL ro_store_t2: wr/rv/flt=%b exp 010", {r1_wr, r1_resp_valid, r1_fault});
        end
        tick;
`endif
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h4E;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        n_cmp++;
        if ({r1_resp_valid, r1_fault} !== 2'b10 || r1_rdata !== 16'h0000) begin
            n_bad++;
            $display("FAIL ro_readback: rv/flt=%b rdata=%h exp 10 0000", {r1_resp_valid, r1_fault}, r1_rdata);
        end
        tick;
    endtask

    task automatic test_sw_load;
        sw = 16'h9876;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h4E;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        n_cmp++;
        if ({r1_resp_valid, r1_fault} !== 2'b10 || r1_rdata !== 16'h9876) begin
            n_bad++;
            $display("FAIL sw_load: rv/flt=%b rdata=%h exp 10 9876", {r1_resp_valid, r1_fault}, r1_rdata);
        end
        tick;
        sw = 16'h0000;
    endtask

    task automatic test_back_to_back;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 16'h5555;
        tick;
        req_write = 1'b0; req_addr = 8'h74;
        n_cmp++;
        if ({r1_ready, r1_wr, r1_rd} !== 3'b010 || r1_addr !== 8'h10) begin
            n_bad++;
            $display("FAIL b2b_t1: rdy/wr/rd=%b addr=%h exp 010 10", {r1_ready, r1_wr, r1_rd}, r1_addr);
        end
        tick;
        n_cmp++;
        if ({r1_ready, r1_wr, r1_rd, r1_resp_valid} !== 4'b0001 || r1_addr !== 8'h10) begin
            n_bad++;
            $display("FAIL b2b_t2: rdy/wr/rd/rv=%b addr=%h exp 0001 10", {r1_ready, r1_wr, r1_rd, r1_resp_valid}, r1_addr);
        end
        tick;
        n_cmp++;
        if ({r1_ready, r1_wr, r1_rd} !== 3'b100 || r1_addr !== 8'h10) begin
            n_bad++;
            $display("FAIL b2b_t3: rdy/wr/rd=%b addr=%h exp 100 10", {r1_ready, r1_wr, r1_rd}, r1_addr);
        end
        tick;
        req_valid = 1'b0;
        n_cmp++;
        if ({r1_ready, r1_wr, r1_rd} !== 3'b001 || r1_addr !== 8'h74) begin
            n_bad++;
            $display("FAIL b2b_t4: rdy/wr/rd=%b addr=%h exp 001 74", {r1_ready, r1_wr, r1_rd}, r1_addr);
        end
        tick;
        n_cmp++;
        if ({r1_wr, r1_rd} !== 2'b01) begin
            n_bad++;
            $display("FAIL b2b_t5: wr/rd=%b exp 01", {r1_wr, r1_rd});
        end
        tick;
        n_cmp++;
        if (r1_resp_valid !== 1'b1 || r1_rdata !== 16'hABCD) begin
            n_bad++;
            $display("FAIL b2b_t6: rv=%b rdata=%h exp 1 abcd", r1_resp_valid, r1_rdata);
        end
        tick;
        n_cmp++;
        if (mem1[8'h10] !== 16'h5555) begin
            n_bad++;
            $display("FAIL b2b_mem: got %h exp 5555", mem1[8'h10]);
        end
    endtask

    task automatic test_reset_midread;
        logic saw_resp;
        rst3 = 1'b0;
        tick;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h30;
        tick;
        req_valid = 1'b0;
        n_cmp++;
        if (r3_rd !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_rd_t1: got %b exp 1", r3_rd);
        end
        tick;
        #2;
        rst3 = 1'b1;
        #1;
        n_cmp++;
        if ({r3_ready, r3_busy, r3_resp_valid, r3_fault, r3_rd, r3_wr} !== 6'b100000 ||
            r3_addr !== 8'h00 || r3_wdata !== 16'h0000) begin
            n_bad++;
            $display("FAIL mid_rst_async: ctrl=%b addr=%h data=%h exp 100000 00 0000",
                     {r3_ready, r3_busy, r3_resp_valid, r3_fault, r3_rd, r3_wr}, r3_addr, r3_wdata);
        end
        tick;
        rst3 = 1'b0;
        saw_resp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (r3_resp_valid !== 1'b0) saw_resp = 1'b1;
        end
        n_cmp++;
        if (saw_resp !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_no_resp: got %b exp 0", saw_resp);
        end
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h30;
        tick;
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({r3_rd, r3_resp_valid} !== 2'b10) begin
                n_bad++;
                $display("FAIL relaunch_rd%0d: rd/rv=%b exp 10", i, {r3_rd, r3_resp_valid});
            end
            tick;
        end
        n_cmp++;
        if ({r3_rd, r3_resp_valid} !== 2'b01 || r3_rdata !== 16'hC0DE) begin
            n_bad++;
            $display("FAIL relaunch_resp: rd/rv=%b rdata=%h exp 01 c0de", {r3_rd, r3_resp_valid}, r3_rdata);
        end
        tick;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clk = 1'b0;
        rst1 = 1'b1;
        rst3 = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = 8'h00;
        req_wdata = 16'h0000;
        sw = 16'h0000;
        led1 = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 16'h0000;
            mem3[i] = 16'h0000;
        end
        mem3[8'h30] = 16'hC0DE;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        rst1 = 1'b0;
        tick;
        test_store_load;
        test_led;
        test_ro_store;
        test_sw_load;
        test_back_to_back;
        rst1 = 1'b1;
        test_reset_midread;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
